wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 30 +++
 rtl/wb_rr_pick.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback port arbiter: select codes, FSM encoding,
// the hard-wired zero register and small index helpers.
`ifndef WB_PORT_ARBITER_PKG_SV
`define WB_PORT_ARBITER_PKG_SV

package wb_port_arbiter_pkg;

    localparam logic [1:0] WB_SEL_A = 2'd0;
    localparam logic [1:0] WB_SEL_B = 2'd1;
    localparam logic [1:0] WB_SEL_C = 2'd2;

    localparam int WB_REG_ZERO = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } wb_state_t;

    // Round-robin successor of a winner index, wrapping C back to A.
    function automatic logic [1:0] wb_ptr_next(input logic [1:0] win);
        return (win == WB_SEL_C) ? WB_SEL_A : win + 2'd1;
    endfunction

    function automatic logic [2:0] wb_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

`endif

// File: rtl/wb_rr_pick.sv
// Combinational winner selection over three eligible sources, searching in
// priority order starting at i_ptr (tie i_ptr to 0 for fixed A > B > C).
module wb_rr_pick
    import wb_port_arbiter_pkg::*;
(
    input  logic [2:0] i_elig,
    input  logic [1:0] i_ptr,
    output logic [1:0] o_win,
    output logic       o_vld
);

    logic [1:0] w_p0;
    logic [1:0] w_p1;
    logic [1:0] w_p2;

    always_comb begin
        case (i_ptr)
            WB_SEL_B: begin
                w_p0 = WB_SEL_B;
                w_p1 = WB_SEL_C;
                w_p2 = WB_SEL_A;
            end
            WB_SEL_C: begin
                w_p0 = WB_SEL_C;
                w_p1 = WB_SEL_A;
                w_p2 = WB_SEL_B;
            end
            default: begin
                w_p0 = WB_SEL_A;
                w_p1 = WB_SEL_B;
                w_p2 = WB_SEL_C;
            end
        endcase
    end

    always_comb begin
        o_vld = 1'b1;
        o_win = w_p0;
        if (i_elig[w_p0]) begin
            o_win = w_p0;
        end else if (i_elig[w_p1]) begin
            o_win = w_p1;
        end else if (i_elig[w_p2]) begin
            o_win = w_p2;
        end else begin
            o_vld = 1'b0;
            o_win = WB_SEL_A;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU (A), load (B) and
// link (C) writeback sources. Define WB_ARB_ROUND_ROBIN_EN for round-robin,
// otherwise fixed priority A > B > C.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [2:0]        i_req,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [ADDR_W-1:0] i_addr_c,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic [DATA_W-1:0] i_data_c,
    input  logic              i_stall,
    output logic [2:0]        o_gnt,
    output logic [1:0]        o_sel,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_busy
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    logic              r_armed;
    logic [2:0]        r_gnt;
    logic [1:0]        r_sel;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic [2:0]        w_mask;
    logic [2:0]        w_elig;
    logic [1:0]        w_ptr;
    logic [1:0]        w_win;
    logic              w_win_vld;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;
    logic              w_load;
    logic              w_we_nxt;

    // The source granted last cycle sits out one cycle so a held request is
    // never written twice.
    assign w_mask = (r_state == ST_GRANT) ? r_gnt : 3'b000;
    assign w_elig = i_req & ~w_mask;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= WB_SEL_A;
        end else if (w_load) begin
            r_ptr <= wb_ptr_next(w_win);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = WB_SEL_A;
`endif

    wb_rr_pick u_pick (
        .i_elig (w_elig),
        .i_ptr  (w_ptr),
        .o_win  (w_win),
        .o_vld  (w_win_vld)
    );

    always_comb begin
        case (w_win)
            WB_SEL_B: begin
                w_win_addr = i_addr_b;
                w_win_data = i_data_b;
            end
            WB_SEL_C: begin
                w_win_addr = i_addr_c;
                w_win_data = i_data_c;
            end
            default: begin
                w_win_addr = i_addr_a;
                w_win_data = i_data_a;
            end
        endcase
    end

    // Arbitration stays off for the first edge after reset release so that
    // reset deassertion never coincides with a register-file write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (r_armed && w_win_vld && !i_stall) begin
            w_state_nxt = ST_GRANT;
        end
    end

    always_comb begin
        w_load   = (w_state_nxt == ST_GRANT);
        w_we_nxt = w_load && (w_win_addr != ADDR_W'(WB_REG_ZERO));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt   <= 3'b000;
            r_we    <= 1'b0;
            r_sel   <= WB_SEL_A;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_gnt <= w_load ? wb_onehot(w_win) : 3'b000;
            r_we  <= w_we_nxt;
            if (w_load) begin
                r_sel   <= w_win;
                r_waddr <= w_win_addr;
                r_wdata <= w_win_data;
            end
        end
    end

    assign o_gnt   = r_gnt;
    assign o_sel   = r_sel;
    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_busy  = |(i_req & ~r_gnt);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-free
// behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        req = 3'b000;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0, addr_c = '0;
    logic [DATA_W-1:0] data_a = '0, data_b = '0, data_c = '0;
    logic              stall = 1'b0;
    logic [2:0]        gnt;
    logic [1:0]        sel;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;

    int total = 0;
    int bad = 0;

    logic [2:0]        m_gnt;
    logic [1:0]        m_sel;
    int                m_ptr;
    logic              m_we;
    logic              m_ready;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_addr_a (addr_a),
        .i_addr_b (addr_b),
        .i_addr_c (addr_c),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_data_c (data_c),
        .i_stall  (stall),
        .o_gnt    (gnt),
        .o_sel    (sel),
        .o_we     (we),
        .o_waddr  (waddr),
        .o_wdata  (wdata),
        .o_busy   (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = 3'b000; m_sel = 2'd0; m_ptr = 0; m_we = 1'b0;
        m_ready = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    // One clock edge of the arbiter as described by its rules.
    task automatic model_edge();
        logic [2:0] elig;
        int w;
        int start;
        elig = req & ~m_gnt;
        w = -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        if (m_ready && !stall) begin
            for (int k = 0; k < 3; k++) begin
                if (w < 0 && elig[(start + k) % 3]) w = (start + k) % 3;
            end
        end
        m_ready = 1'b1;
        if (w < 0) begin
            m_gnt = 3'b000;
            m_we  = 1'b0;
        end else begin
            m_gnt = 3'(1 << w);
            m_sel = 2'(w);
            case (w)
                0: begin m_waddr = addr_a; m_wdata = data_a; end
                1: begin m_waddr = addr_b; m_wdata = data_b; end
                default: begin m_waddr = addr_c; m_wdata = data_c; end
            endcase
            m_we  = (m_waddr != 0);
            m_ptr = (w + 1) % 3;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("gnt", 64'(gnt), 64'(m_gnt));
            chk("sel", 64'(sel), 64'(m_sel));
            chk("we", 64'(we), 64'(m_we));
            chk("waddr", 64'(waddr), 64'(m_waddr));
            chk("wdata", 64'(wdata), 64'(m_wdata));
            chk("busy", 64'(busy), 64'(|(req & ~m_gnt)));
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_sel"}, 64'(sel), 64'd0);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_waddr"}, 64'(waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // All three request with addresses 1/2/3.
        req = 3'b111;
        addr_a = 5'd1; addr_b = 5'd2; addr_c = 5'd3;
        data_a = 32'hA; data_b = 32'hB; data_c = 32'hC;
        rst_n = 1'b1;
        step(1);
        chk("first_edge_idle", 64'(gnt), 64'd0);
        step(1);
        chk("second_edge_gnt_a", 64'(gnt), 64'd1);
        chk("second_edge_waddr", 64'(waddr), 64'd1);
        chk("second_edge_we", 64'(we), 64'd1);
        step(1);
        chk("third_edge_gnt_b", 64'(gnt), 64'd2);
        step(1);
`ifdef WB_ARB_ROUND_ROBIN_EN
        chk("fourth_edge_gnt_c", 64'(gnt), 64'd4);
`else
        chk("fourth_edge_gnt_a", 64'(gnt), 64'd1);
`endif

        // Single continuous requester: one write every two cycles.
        req = 3'b001; addr_a = 5'd5; data_a = 32'h1234_5678;
        step(6);

        // Write to register 0 is suppressed but still granted.
        req = 3'b000;
        step(1);
        req = 3'b010; addr_b = 5'd0; data_b = 32'hDEAD_BEEF;
        step(1);
        chk("zero_reg_gnt", 64'(gnt), 64'd2);
        chk("zero_reg_we", 64'(we), 64'd0);
        req = 3'b000;
        step(1);
        req = 3'b111; addr_b = 5'd7;
        step(1);
`ifdef WB_ARB_ROUND_ROBIN_EN
        chk("ptr_after_zero_reg", 64'(gnt), 64'd4);
`else
        chk("fixed_after_zero_reg", 64'(gnt), 64'd1);
`endif

        // Stall blocks grants, then A wins once released.
        req = 3'b000;
        step(2);
        req = 3'b101; stall = 1'b1;
        step(3);
        stall = 1'b0;
        step(1);
        step(3);

        // Asynchronous reset in a grant cycle.
        req = 3'b111;
        for (int i = 0; i < 4 && m_gnt == 3'b000; i++) step(1);
        chk("pre_reset_has_grant", 64'(gnt != 3'b000), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req    = 3'($urandom_range(0, 7));
            stall  = ($urandom_range(0, 7) == 0);
            addr_a = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
            addr_b = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
            addr_c = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
            data_a = $urandom;
            data_b = $urandom;
            data_c = $urandom;
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
